// File: rtl/param_mux_scan_pkg.sv
// Shared encodings and helpers for the registered channel multiplexer.
// Imported by the prescaler, the top level and the bench.
package param_mux_scan_pkg;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_SCAN   = 2'd1,
    S_FROZEN = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_mux_scan_prescaler.sv
// Scan prescaler: counts 0..SCAN_PERIOD-1 while enabled and
// strobes tick on the terminal count, then wraps to zero.
module scan_prescaler
  import param_mux_scan_pkg::*;
#(
  parameter int SCAN_PERIOD = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = clog2(SCAN_PERIOD) + 1;
  localparam logic [PW-1:0] TERM = PW'(SCAN_PERIOD - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable)
      cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/param_mux_scan.sv
// N-to-1 registered channel multiplexer with manual select,
// rotating scan and freeze; data and index are registered together.
module param_mux_scan
  import param_mux_scan_pkg::*;
#(
  parameter  int WIDTH       = 4,
  parameter  int CHANNELS    = 4,
  parameter  int SCAN_PERIOD = 50000,
  localparam int SEL_W       = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic [CHANNELS-1:0]       chan_onehot,
  output logic                      tick
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [WIDTH-1:0]    data_q;
  logic [CHANNELS-1:0] onehot_q;
  logic                tick_q;
  logic                entering, scanning, adv;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      hold:                        state_d = S_FROZEN;
      (!hold && mode == MODE_SCAN):   state_d = S_SCAN;
      (!hold && mode == MODE_MANUAL): state_d = S_MANUAL;
      default: ;
    endcase
  end

  // Any entry into scan restarts the prescaler from zero.
  assign entering = (state_d == S_SCAN) && (state_q != S_SCAN);
  assign scanning = (state_d == S_SCAN) && (state_q == S_SCAN);

  scan_prescaler #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_pre (
    .clk   (clk),
    .rst   (rst),
    .clear (entering),
    .enable(scanning),
    .tick  (adv)
  );

  always_comb begin
    chan_d = chan_q;
    if (state_d == S_MANUAL) begin
      if (int'(sel) < CHANNELS)
        chan_d = sel;
    end else if (adv) begin
      chan_d = (chan_q == LAST) ? '0 : chan_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_MANUAL;
      chan_q   <= '0;
      data_q   <= '0;
      onehot_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      data_q   <= in_bus[int'(chan_d)*WIDTH +: WIDTH];
      onehot_q <= CHANNELS'(1) << chan_d;
      tick_q   <= adv;
    end
  end

  assign data_out    = data_q;
  assign chan_out    = chan_q;
  assign chan_onehot = onehot_q;
  assign tick        = tick_q;

endmodule
